// File: rtl/uart_pkg.sv
// Shared UART types and helpers.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud_rate
  );
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// N-stage synchronizer for an asynchronous level.
// Flops reset to RESET_VAL so an idle line reads idle.
module uart_rx_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : g_bad_stages
    $error("uart_rx_sync needs STAGES >= 2");
  end

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ff <= {STAGES{RESET_VAL}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling.
// Bytes leave through a valid/ready holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CLKS_PER_BIT =
    clks_per_bit(clk_freq, baud_rate);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int SYNC_STAGES = 2;

  localparam logic [CW-1:0] CNT_LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF =
    CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] CNT_SETTLE =
    CW'(SYNC_STAGES);
  localparam logic [2:0] IDX_LAST =
    3'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_rate
    $error("uart_rx: clk_freq/baud_rate must be >= 4");
  end

  logic rx_s;

  uart_rx_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (IDLE_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  rx_state_t            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           bit_idx, idx_n;
  logic [DATA_BITS-1:0] shreg, sh_n;
  logic [7:0]           data_n;
  logic                 valid_n;
  logic                 ferr_n;
  logic                 ovr_n;
  logic                 good;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= WAIT_HIGH;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= idx_n;
      shreg     <= sh_n;
      rx_data   <= data_n;
      rx_valid  <= valid_n;
      frame_err <= ferr_n;
      overrun   <= ovr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = bit_idx;
    sh_n    = shreg;
    data_n  = rx_data;
    valid_n = rx_valid;
    ferr_n  = 1'b0;
    ovr_n   = 1'b0;
    good    = 1'b0;

    if (rx_valid && rx_ready) begin
      valid_n = 1'b0;
    end

    unique case (state)
      // Line must read idle longer than the
      // synchronizer depth so its reset value flushes.
      WAIT_HIGH: begin
        if (rx_s != IDLE_LEVEL) begin
          cnt_n = '0;
        end else if (cnt == CNT_SETTLE) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      IDLE: begin
        cnt_n = '0;
        if (rx_s != IDLE_LEVEL) begin
          state_n = START;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = (rx_s == IDLE_LEVEL) ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          sh_n  = {rx_s, shreg[DATA_BITS-1:1]};
          idx_n = bit_idx + 1'b1;
          if (bit_idx == IDX_LAST) begin
            state_n = STOP;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (rx_s == IDLE_LEVEL) begin
            good    = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = WAIT_HIGH;
      end
    endcase

    if (good) begin
      if (!rx_valid || rx_ready) begin
        data_n  = shreg;
        valid_n = 1'b1;
      end else begin
        ovr_n = 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx.
// A line model drives frames; a monitor checks deliveries.
module tb_uart_rx;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 50000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int HALF     = CPB / 2;
  localparam int LAT      = 2 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(
    .clk_freq  (CLK_FREQ),
    .baud_rate (BAUD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         start;
    bit         chk_lat;
  } exp_t;

  exp_t exp_q[$];
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int n_valid = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  always @(negedge clk) begin : mon
    exp_t it;
    int   lat;
    if (rst) begin
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (rx_valid && rx_ready) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_valid: got %02h expected none",
                   rx_data);
        end else begin
          it = exp_q.pop_front();
          chk("rx_data", {24'd0, rx_data}, {24'd0, it.data});
          if (it.chk_lat) begin
            lat = cyc - it.start;
            n_chk++;
            if (lat >= LAT - 3 && lat <= LAT + 3) n_pass++;
            else $display("FAIL latency: got %0d expected %0d+/-3",
                          lat, LAT);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(
    input logic [7:0] b,
    input logic       stop,
    input bit         expect_good,
    input bit         chk_lat
  );
    exp_t it;
    if (expect_good) begin
      it.data = b;
      it.start = cyc;
      it.chk_lat = chk_lat;
      exp_q.push_back(it);
    end
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
  endtask

  initial begin : guard
    #1500000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit all_busy;
    bit seen;
    // reset state
    tick(2);
    chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
    chk("rst_rx_valid", {31'd0, rx_valid}, 0);
    chk("rst_frame_err", {31'd0, frame_err}, 0);
    chk("rst_overrun", {31'd0, overrun}, 0);
    chk("rst_busy_wait_high", {31'd0, busy}, 1);
    rst = 1'b1;
    tick(8);
    chk("idle_busy", {31'd0, busy}, 0);

    // 1: single byte, ready high
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    tick(CPB);
    chk("t1_queue_empty", exp_q.size(), 0);
    chk("t1_n_valid", n_valid, 1);
    chk("t1_frame_err", ferr_cnt, 0);
    chk("t1_overrun", ovr_cnt, 0);

    // 2: short glitch rejected in START
    rx = 1'b0;
    tick(6);
    chk("t2_busy_in_glitch", {31'd0, busy}, 1);
    rx = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < HALF + 3; i++) begin
      if (!busy) seen = 1'b1;
      if (!seen) tick(1);
    end
    chk("t2_busy_released", {31'd0, busy}, 0);
    tick(12 * CPB);
    chk("t2_n_valid", n_valid, 1);

    // 3: bad stop, line held low, then good frame
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    all_busy = 1'b1;
    for (int i = 0; i < 3 * CPB; i++) begin
      if (!busy) all_busy = 1'b0;
      tick(1);
    end
    chk("t3_busy_low", {31'd0, all_busy}, 1);
    rx = 1'b1;
    tick(2 * CPB);
    chk("t3_frame_err", ferr_cnt, 1);
    chk("t3_no_valid_3c", n_valid, 1);
    send_frame(8'h55, 1'b1, 1'b1, 1'b1);
    tick(CPB);
    chk("t3_n_valid", n_valid, 2);

    // 4: overrun with consumer stalled
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    tick(CPB);
    chk("t4_valid_held", {31'd0, rx_valid}, 1);
    chk("t4_data_11", {24'd0, rx_data}, 32'h11);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    tick(CPB);
    chk("t4_overrun", ovr_cnt, 1);
    chk("t4_data_kept", {24'd0, rx_data}, 32'h11);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(1);
    chk("t4_valid_clr", {31'd0, rx_valid}, 0);
    chk("t4_data_after", {24'd0, rx_data}, 32'h11);
    chk("t4_n_valid", n_valid, 3);
    rx_ready = 1'b1;

    // 5: reset during data bit 4, line low at release
    rx = 1'b0;
    tick(5 * CPB + HALF);
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    chk("t5_rx_data", {24'd0, rx_data}, 32'h00);
    chk("t5_rx_valid", {31'd0, rx_valid}, 0);
    chk("t5_frame_err", {31'd0, frame_err}, 0);
    chk("t5_overrun", {31'd0, overrun}, 0);
    tick(2 * CPB);
    chk("t5_wait_high", {31'd0, busy}, 1);
    rx = 1'b1;
    tick(CPB);
    chk("t5_idle", {31'd0, busy}, 0);
    tick(12 * CPB);
    chk("t5_no_byte", n_valid, 3);
    chk("t5_no_ferr", ferr_cnt, 1);

    // 6: back-to-back stream of every byte value
    for (int b = 0; b < 256; b++) begin
      send_frame(8'(b), 1'b1, 1'b1, 1'b1);
    end
    tick(2 * CPB);
    chk("t6_n_valid", n_valid, 259);
    chk("t6_queue_empty", exp_q.size(), 0);
    chk("t6_frame_err", ferr_cnt, 1);
    chk("t6_overrun", ovr_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver paired with the team's UART transmitter; consumes the transmitter's `tx` line (or an external pin) and produces parallel bytes.
- Frame format: 8N1 (start bit, 8 data bits LSB first, 1 stop bit).
- Runs entirely in the system clock domain with a mid-bit sampling counter; no derived clock.
- Delivers bytes through a valid/ready holding register and flags framing and overrun errors.

Parameters:
- clk_freq, 1000000, system clock frequency in Hz.
- baud_rate, 9600, line bit rate in bits/s.
- Derived: CLKS_PER_BIT = clk_freq/baud_rate (integer divide, 104 at defaults); HALF_BIT = CLKS_PER_BIT/2 (52).
- Elaboration error if CLKS_PER_BIT < 4.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset; one clock; reset is synchronous and active-low.
- rx  input  1  asynchronous serial line, idle high.
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
- rx_data  output  8  received byte, stable while rx_valid=1.
- rx_valid  output  1  holding register full.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: good frame dropped because the holding register was full.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Input sync: rx passes through a 2-flop synchronizer to give rx_s. Sync flops reset to 1.
- Reset (rst=0 at posedge) values:
  - rx_data=0x00, rx_valid=0, frame_err=0, overrun=0.
  - Bit counter=0, shift register=0.
  - State=WAIT_HIGH.
  - Reset mid-frame abandons the frame and delivers no partial byte.
- States (enum in package):
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. Prevents a line held low (through reset or a break) from being taken as a start bit.
  - IDLE: cnt=0. If rx_s==0, go to START.
  - START: cnt increments each clock. At cnt==HALF_BIT-1:
    - rx_s==0: go to DATA with cnt=0, bit_idx=0.
    - rx_s==1: glitch; go to IDLE with no outputs.
  - DATA: at cnt==CLKS_PER_BIT-1, sample rx_s into the shift register (shift right, new bit into [7], so LSB is received first), set cnt=0, bit_idx++. After the 8th sample (bit_idx==7), go to STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rx_s:
    - rx_s==1: good frame, go to IDLE (deliver byte, see holding register).
    - rx_s==0: frame_err=1 for one cycle, byte discarded, go to WAIT_HIGH.
- Holding register:
  - Good frame and (rx_valid==0 or rx_ready==1): load rx_data, set rx_valid=1.
  - Good frame and rx_valid==1 and rx_ready==0: keep the old rx_data, drop the new byte, overrun=1 for one cycle.
  - rx_valid && rx_ready with no frame completing: clear rx_valid next cycle.
  - Simultaneous accept and completion: new byte loaded, rx_valid stays 1, no overrun.
- Latency: rx_valid rises 2 + HALF_BIT + 9*CLKS_PER_BIT (+/-1) clocks after rx falls at the start bit (990 at defaults). The bench allows +/-3 clocks.
- Counters:
  - cnt is $clog2(CLKS_PER_BIT) bits and never exceeds CLKS_PER_BIT-1.
  - bit_idx is 3 bits.
- Sampling points are mid-bit: HALF_BIT, then full periods.
- Re-arm after a good frame: IDLE can accept a new start bit immediately after the mid-stop sample, which tolerates up to about 4% baud mismatch.
- busy = (state != IDLE). WAIT_HIGH counts as busy.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum {WAIT_HIGH, IDLE, START, DATA, STOP}.
  - Function clks_per_bit(clk_freq, baud_rate).
  - Constants DATA_BITS=8, line IDLE_LEVEL=1'b1.
  - Shared with the transmitter for its own state enum.
- One sub-module: uart_rx_sync (parameterised N-stage synchronizer, default 2, reset value 1).
- The FSM, counters and holding register stay in uart_rx.

Test Plan:
1. Line model sends 0xA5 at 9600 baud, rx_ready=1 → one-cycle rx_valid with rx_data=0xA5 about 990 clocks after the start edge; frame_err=0, overrun=0.
2. rx low for 20 clocks then high → START rejects the glitch; no rx_valid; busy returns to 0 within HALF_BIT+3 clocks.
3. Frame 0x3C with stop bit driven 0, then line held low 3 bit times, then high, then frame 0x55 → one frame_err pulse and no rx_valid for 0x3C; busy held through the low period; rx_data=0x55 then received correctly.
4. rx_ready=0; frames 0x11 then 0x22 → rx_valid=1 with rx_data=0x11; overrun pulse at the end of 0x22. Assert rx_ready for one cycle → rx_valid=0 and rx_data remains 0x11.
5. rst=0 for 2 clocks during data bit 4, with rx low at release → all outputs at reset values; state WAIT_HIGH until rx high; no byte emitted for the aborted frame.
6. Loopback from the team's transmitter (same clk_freq/baud_rate), bytes 0x00..0xFF back-to-back → 256 rx_valid pulses with matching data in order; zero frame_err and zero overrun.
